// File: rtl/onchip_mem_pkg.sv
// Shared definitions for the on-chip frame memory burst reader:
// sizing helper, FSM encoding and byte-mask generators.
package onchip_mem_pkg;

    // Widest word the mask helpers support (DATA_W up to 1024).
    localparam int MAX_NB = 128;

    typedef logic [MAX_NB-1:0] mask_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction

    // Bytes at or above the start offset within an nb-byte word.
    function automatic mask_t first_mask(input int off, input int nb);
        mask_t m;
        m = '0;
        for (int i = 0; i < MAX_NB; i++) m[i] = (i >= off) && (i < nb);
        return m;
    endfunction

    // Bytes at or below the final byte offset within an nb-byte word.
    function automatic mask_t last_mask(input int end_off, input int nb);
        mask_t m;
        m = '0;
        for (int i = 0; i < MAX_NB; i++) m[i] = (i <= end_off) && (i < nb);
        return m;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO. Head entry is visible on
// pop_data whenever empty is low; pop consumes it.
module sync_fifo_fwft
    import onchip_mem_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    used,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so
    // pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= push_data;
    end

    assign pop_data = mem[rp];
    assign used     = cnt;
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);

endmodule

// File: rtl/onchip_mem_burst_reader.sv
// Byte-granular burst reader: issues one word read per cycle to the
// on-chip frame RAM, tags returns with byte enables and a last flag,
// and streams them out through a FWFT FIFO. Reads are only issued when
// the FIFO is guaranteed room for the return (credit scheme).
module onchip_mem_burst_reader
    import onchip_mem_pkg::*;
#(
    parameter  int DATA_W     = 256,
    parameter  int ADDR_W     = 18,
    parameter  int MEM_LAT    = 2,
    parameter  int FIFO_DEPTH = 128,
    localparam int NB         = DATA_W / 8,
    localparam int OFF_W      = clog2(NB),
    localparam int WA_W       = ADDR_W - OFF_W,
    localparam int CNT_W      = clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_chip_select,
    output logic              mem_clk_ena,
    output logic              mem_read,
    output logic [WA_W-1:0]   mem_addr,
    input  logic              mem_read_valid,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [ADDR_W-1:0] start_addr_in,
    input  logic [31:0]       byte_len_in,
    input  logic              start_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NB-1:0]     out_be,
    output logic              out_last
);

    localparam int FW = DATA_W + NB + 1;

    state_t            state;
    logic [WA_W-1:0]   waddr;
    logic [OFF_W-1:0]  off_q;
    logic [OFF_W-1:0]  end_off_q;
    logic [32:0]       nwords;
    logic [32:0]       issued;
    logic [32:0]       rc;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_used;
    logic              fifo_full;
    logic              fifo_empty;
    logic              busy_q;
    logic              done_q;
    logic              read_q;
    logic [WA_W-1:0]   addr_q;

    logic [32:0]       span;
    logic [CNT_W:0]    occupancy;
    logic              issue_now;
    logic              push;
    logic              rc_last;
    logic [NB-1:0]     be_c;
    mask_t             fm_full;
    mask_t             lm_full;
    logic [FW-1:0]     fifo_out;

    // Offset of the final byte relative to the first word, 33-bit so a
    // full 32-bit length plus offset cannot wrap.
    assign span = {1'b0, byte_len_in} + 33'(start_addr_in[OFF_W-1:0]) - 33'd1;

    // Entries already queued plus reads still in flight must stay within
    // the FIFO, independent of memory latency.
    assign occupancy = {1'b0, fifo_used} + {1'b0, inflight};
    assign issue_now = (state == ST_ISSUE) && (issued < nwords)
                       && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

    // Returns outside an active burst (e.g. after an abort) are dropped.
    assign push    = (state != ST_IDLE) && mem_read_valid;
    assign rc_last = (rc == nwords - 33'd1);

    // Byte enables: trim leading bytes on the first word, trailing bytes
    // on the last word.
    always_comb begin
        fm_full = first_mask(int'(off_q), NB);
        lm_full = last_mask(int'(end_off_q), NB);
        be_c    = '1;
        if (rc == '0) be_c = be_c & fm_full[NB-1:0];
        if (rc_last)  be_c = be_c & lm_full[NB-1:0];
    end

    // Burst control FSM with registered memory-side and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            waddr     <= '0;
            off_q     <= '0;
            end_off_q <= '0;
            nwords    <= '0;
            issued    <= '0;
            rc        <= '0;
            inflight  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            read_q    <= 1'b0;
            addr_q    <= '0;
        end else begin
            read_q   <= 1'b0;
            done_q   <= 1'b0;
            inflight <= inflight + CNT_W'(issue_now) - CNT_W'(push);
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        if (byte_len_in == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            off_q     <= start_addr_in[OFF_W-1:0];
                            waddr     <= start_addr_in[ADDR_W-1:OFF_W];
                            nwords    <= (span >> OFF_W) + 33'd1;
                            end_off_q <= span[OFF_W-1:0];
                            issued    <= '0;
                            rc        <= '0;
                            busy_q    <= 1'b1;
                            state     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (issue_now) begin
                        read_q <= 1'b1;
                        addr_q <= waddr;
                        waddr  <= waddr + WA_W'(1);
                        issued <= issued + 33'd1;
                        if (issued + 33'd1 == nwords) state <= ST_DRAIN;
                    end
                end
                default: ;
            endcase
            if (push) begin
                rc <= rc + 33'd1;
                if (rc_last) begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({mem_read_data, be_c, rc_last}),
        .pop       (out_ready),
        .pop_data  (fifo_out),
        .used      (fifo_used),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign mem_chip_select = busy_q;
    assign mem_clk_ena     = 1'b1;
    assign mem_read        = read_q;
    assign mem_addr        = addr_q;
    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign out_valid       = ~fifo_empty;
    assign out_data        = fifo_out[FW-1 -: DATA_W];
    assign out_be          = fifo_out[NB:1];
    assign out_last        = fifo_out[0];

endmodule

// File: tb/tb_onchip_mem_burst_reader.sv
// Scoreboard bench for onchip_mem_burst_reader: directed bursts push
// expected addresses/words; a negedge monitor pops and compares.
module tb_onchip_mem_burst_reader;

    localparam int DATA_W     = 256;
    localparam int ADDR_W     = 18;
    localparam int MEM_LAT    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int NB         = 32;
    localparam int WA_W       = 13;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [NB-1:0]     be;
        logic              last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_chip_select, mem_clk_ena, mem_read;
    logic [WA_W-1:0]   mem_addr;
    logic              mem_read_valid;
    logic [DATA_W-1:0] mem_read_data;
    logic [ADDR_W-1:0] start_addr_in;
    logic [31:0]       byte_len_in;
    logic              start_in;
    logic              busy_out, done_out, out_valid, out_ready, out_last;
    logic [DATA_W-1:0] out_data;
    logic [NB-1:0]     out_be;

    int compared   = 0;
    int mismatched = 0;
    int reads_seen = 0;
    int pops_seen  = 0;
    int done_cnt   = 0;
    bit addr_chk   = 1'b1;

    exp_t            sb_q[$];
    logic [WA_W-1:0] addr_q[$];

    always #5 clk = ~clk;

    onchip_mem_burst_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_chip_select(mem_chip_select), .mem_clk_ena(mem_clk_ena),
        .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_read_valid(mem_read_valid), .mem_read_data(mem_read_data),
        .start_addr_in(start_addr_in), .byte_len_in(byte_len_in), .start_in(start_in),
        .busy_out(busy_out), .done_out(done_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_be(out_be), .out_last(out_last)
    );

    // Word contents as a function of word address.
    function automatic logic [DATA_W-1:0] pat(input logic [WA_W-1:0] a);
        logic [DATA_W-1:0] p;
        for (int k = 0; k < 8; k++) p[32*k +: 32] = 32'(a) * 32'h9E37 + 32'(k) * 32'h01010101;
        return p;
    endfunction

    // Fixed-latency memory model, not reset: returns of an aborted
    // burst still arrive after the DUT is reset.
    logic [MEM_LAT:1] vld_pipe = '0;
    logic [WA_W-1:0]  addr_pipe [MEM_LAT:1];
    always @(posedge clk) begin
        vld_pipe[1]  <= mem_read;
        addr_pipe[1] <= mem_addr;
        for (int i = 2; i <= MEM_LAT; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
        end
    end
    assign mem_read_valid = vld_pipe[MEM_LAT];
    assign mem_read_data  = pat(addr_pipe[MEM_LAT]);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: read addresses, output words, done pulses, credit bound.
    always @(negedge clk) begin
        exp_t e;
        logic [WA_W-1:0] ea;
        if (!rst_n) begin
            reads_seen = 0;
            pops_seen  = 0;
        end else begin
            if (mem_read) begin
                reads_seen++;
                if (addr_chk) begin
                    compared++;
                    if (addr_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL mem_addr: unexpected read at %0h", mem_addr);
                    end else begin
                        ea = addr_q.pop_front();
                        if (mem_addr !== ea) begin
                            mismatched++;
                            $display("FAIL mem_addr: got %0h expected %0h", mem_addr, ea);
                        end
                    end
                end
            end
            if (out_valid && out_ready) begin
                pops_seen++;
                compared++;
                if (sb_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL out_word: unexpected word be=%h last=%b", out_be, out_last);
                end else begin
                    e = sb_q.pop_front();
                    if ({out_data, out_be, out_last} !== e) begin
                        mismatched++;
                        $display("FAIL out_word: got be=%h last=%b data=%h, expected be=%h last=%b data=%h",
                                 out_be, out_last, out_data, e.be, e.last, e.data);
                    end
                end
            end
            if (done_out) done_cnt++;
            if (reads_seen - pops_seen > FIFO_DEPTH) begin
                mismatched++;
                $display("FAIL overflow: outstanding %0d exceeds depth %0d", reads_seen - pops_seen, FIFO_DEPTH);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WA_W-1:0] a, input logic [NB-1:0] be, input logic last);
        sb_q.push_back({pat(a), be, last});
        addr_q.push_back(a);
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic [31:0] len);
        start_addr_in = a;
        byte_len_in   = len;
        start_in      = 1'b1;
        tick(1);
        start_in      = 1'b0;
    endtask

    // Bounded wait for done and an empty scoreboard, then check that
    // exactly one done pulse was seen.
    task automatic finish_burst(input string nm, input int d0);
        int n;
        n = 0;
        while ((done_cnt == d0 || sb_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            mismatched++;
            $display("FAIL %s_timeout: done_cnt=%0d queued=%0d", nm, done_cnt - d0, sb_q.size());
        end
        tick(3);
        chk({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        int r0;
        rst_n = 1'b0; start_in = 1'b0; start_addr_in = '0; byte_len_in = '0; out_ready = 1'b1;
        tick(3);
        @(negedge clk);
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_chip_sel", 64'(mem_chip_select), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_busy",     64'(busy_out), 64'd0);
        chk("rst_done",     64'(done_out), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("clk_ena",      64'(mem_clk_ena), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(2);

        // Aligned: words 2,3 full enables.
        push_word(13'd2, 32'hFFFFFFFF, 1'b0);
        push_word(13'd3, 32'hFFFFFFFF, 1'b1);
        d0 = done_cnt;
        pulse_start(18'h40, 32'd64);
        @(negedge clk);
        chk("aligned_busy", 64'(busy_out), 64'd1);
        finish_burst("aligned", d0);
        chk("aligned_idle", 64'(busy_out), 64'd0);

        // Unaligned: offset 5, 40 bytes spans words 0,1.
        push_word(13'd0, 32'hFFFFFFE0, 1'b0);
        push_word(13'd1, 32'h00001FFF, 1'b1);
        d0 = done_cnt;
        pulse_start(18'd5, 32'd40);
        finish_burst("unaligned", d0);

        // Single word, bytes 3..6.
        push_word(13'd0, 32'h00000078, 1'b1);
        d0 = done_cnt;
        pulse_start(18'd3, 32'd4);
        finish_burst("single", d0);

        // Zero length: done exactly one cycle after start, no reads.
        r0 = reads_seen;
        start_addr_in = 18'h100; byte_len_in = 32'd0; start_in = 1'b1;
        @(negedge clk);
        chk("zero_done_t0", 64'(done_out), 64'd0);
        @(posedge clk); #1;
        start_in = 1'b0;
        @(negedge clk);
        chk("zero_done_t1", 64'(done_out), 64'd1);
        chk("zero_busy", 64'(busy_out), 64'd0);
        @(negedge clk);
        chk("zero_done_t2", 64'(done_out), 64'd0);
        tick(4);
        chk("zero_no_reads", 64'(reads_seen - r0), 64'd0);

        // Backpressure: 10 words, FIFO of 4, consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_word(13'(i), 32'hFFFFFFFF, i == 9);
        r0 = reads_seen;
        d0 = done_cnt;
        pulse_start(18'd0, 32'd320);
        tick(30);
        @(negedge clk);
        chk("bp_reads_stalled", 64'(reads_seen - r0), 64'd4);
        chk("bp_read_low", 64'(mem_read), 64'd0);
        chk("bp_busy", 64'(busy_out), 64'd1);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        finish_burst("bp", d0);
        chk("bp_reads_total", 64'(reads_seen - r0), 64'd10);

        // Reset in cycle 3 of a 10-word burst, then a fresh one-word burst.
        out_ready = 1'b0;
        addr_chk  = 1'b0;
        pulse_start(18'h800, 32'd320);
        tick(2);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy_out), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        tick(6);
        @(negedge clk);
        chk("abort_stale_dropped", 64'(out_valid), 64'd0);
        chk("abort_no_reads", 64'(reads_seen), 64'd0);
        @(posedge clk); #1;
        addr_chk  = 1'b1;
        out_ready = 1'b1;
        push_word(13'd0, 32'hFFFFFFFF, 1'b1);
        d0 = done_cnt;
        pulse_start(18'd0, 32'd32);
        finish_burst("post_reset", d0);
        @(negedge clk);
        chk("post_reset_empty", 64'(out_valid), 64'd0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
